// File: rtl/button_debouncer.sv
// Synchroniser plus counter-qualified debounce FSM for the nibble-load push button.
// Define BTN_AUTOREPEAT_EN to add auto-repeat strobes while the button stays held.
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W = $clog2(
        (DEBOUNCE_CYCLES >= REPEAT_DELAY && DEBOUNCE_CYCLES >= REPEAT_PERIOD) ? DEBOUNCE_CYCLES :
        (REPEAT_DELAY >= REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic button_in,
    output logic button_s,
    output logic button_pulse,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   press_d;
    logic                   rpt_hit;
    logic                   button_s_q, button_pulse_q, busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[SYNC_STAGES-2:0], button_in};
    end
    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        unique case (state_q)
            IDLE: if (sync_bit) begin
                state_d = PRESS_WAIT;
                cnt_d   = '0;
            end
            PRESS_WAIT: begin
                if (!sync_bit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: if (!sync_bit) begin
                state_d = RELEASE_WAIT;
                cnt_d   = '0;
            end
            RELEASE_WAIT: begin
                // Returning to PRESSED is a rejected release bounce, never a new press.
                if (sync_bit) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_arm_q, rpt_arm_d;

    // Counts only across edges that stay in PRESSED; any other state restarts the delay.
    always_comb begin
        rpt_cnt_d = '0;
        rpt_arm_d = 1'b0;
        rpt_hit   = 1'b0;
        if (state_q == PRESSED && state_d == PRESSED) begin
            if (rpt_cnt_q == (rpt_arm_q ? RPT_NEXT : RPT_FIRST)) begin
                rpt_hit   = 1'b1;
                rpt_arm_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
                rpt_arm_d = rpt_arm_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt_q <= '0;
            rpt_arm_q <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_arm_q <= rpt_arm_d;
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            button_s_q     <= 1'b0;
            button_pulse_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            button_s_q     <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
            button_pulse_q <= press_d | rpt_hit;
            busy_q         <= (state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT);
        end
    end

    assign button_s     = button_s_q;
    assign button_pulse = button_pulse_q;
    assign busy         = busy_q;
endmodule
